// File: rtl/uart_frame_receiver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : uart_frame_receiver
// Brief   : 16x-oversampled UART receiver with 3-sample vote, error/break
//           flags and a valid/ready word output.
// Revision: 1.0
// ----------------------------------------------------------------------------
module uart_frame_receiver #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_baud_16x,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 rx_enable,
  output logic [DATA_BITS-1:0] recv_data,
  output logic                 recv_valid,
  input  logic                 recv_ready,
  output logic                 recv_parity_error,
  output logic                 recv_framing_error,
  output logic                 recv_break,
  output logic                 recv_overrun,
  output logic                 recv_busy
);

  localparam logic [3:0] c_data_bits = 4'(DATA_BITS);
  localparam logic [3:0] c_last_stop = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_sync_meta;
  logic                 r_rx_sync;
  logic [3:0]           r_phase;
  logic [3:0]           r_bit_cnt;
  logic                 r_s7;
  logic                 r_s8;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_all_zero;
  logic                 w_frame_end;
  logic                 w_is_break;

  wire w_mid  = (r_phase == 4'd9);
  wire w_end  = (r_phase == 4'd15);
  wire w_vote = (r_s7 & r_s8) | (r_s7 & r_rx_sync) | (r_s8 & r_rx_sync);
  wire w_par_calc = (^r_shift) ^ w_vote;

  always_ff @(posedge clk_baud_16x or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_frame_end  = 1'b0;
    w_is_break   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_enable && !r_rx_sync) w_state_next = S_START;
      end
      S_START: begin
        if (w_mid && w_vote)  w_state_next = S_IDLE;
        else if (w_end)       w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_end && r_bit_cnt == c_data_bits)
          w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_end) w_state_next = S_STOP;
      end
      S_STOP: begin
        // A break is recognised on the first stop bit, even with two stop bits.
        if (w_mid) begin
          if (r_bit_cnt == 4'd0 && r_all_zero && !w_vote) begin
            w_frame_end  = 1'b1;
            w_is_break   = 1'b1;
            w_state_next = S_BREAK;
          end else if (r_bit_cnt == c_last_stop) begin
            w_frame_end  = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        if (r_rx_sync) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (!rx_enable) begin
      w_state_next = S_IDLE;
      w_frame_end  = 1'b0;
      w_is_break   = 1'b0;
    end
  end

  always_ff @(posedge clk_baud_16x or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_meta <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_phase     <= 4'd0;
      r_bit_cnt   <= 4'd0;
      r_s7        <= 1'b1;
      r_s8        <= 1'b1;
      r_shift     <= '0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_all_zero  <= 1'b1;
    end else begin
      r_sync_meta <= rx;
      r_rx_sync   <= r_sync_meta;
      if (r_phase == 4'd7) r_s7 <= r_rx_sync;
      if (r_phase == 4'd8) r_s8 <= r_rx_sync;
      if (r_state == S_IDLE) begin
        r_phase    <= 4'd0;
        r_bit_cnt  <= 4'd0;
        r_perr     <= 1'b0;
        r_ferr     <= 1'b0;
        r_all_zero <= 1'b1;
      end else begin
        r_phase <= r_phase + 4'd1;
      end
      if (r_state == S_DATA) begin
        if (w_mid) begin
          r_shift    <= {w_vote, r_shift[DATA_BITS-1:1]};
          r_bit_cnt  <= r_bit_cnt + 4'd1;
          r_all_zero <= r_all_zero & ~w_vote;
        end else if (w_state_next != S_DATA) begin
          r_bit_cnt <= 4'd0;
        end
      end
      if (r_state == S_PARITY && w_mid) begin
        r_perr     <= (PARITY == 1) ? ~w_par_calc : w_par_calc;
        r_all_zero <= r_all_zero & ~w_vote;
      end
      if (r_state == S_STOP && w_mid) begin
        r_ferr    <= r_ferr | ~w_vote;
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
    end
  end

  // Output holding register: a word that finishes while the previous one is
  // still unaccepted is dropped and only recorded as an overrun.
  always_ff @(posedge clk_baud_16x or negedge reset_n) begin
    if (!reset_n) begin
      recv_data          <= '0;
      recv_valid         <= 1'b0;
      recv_parity_error  <= 1'b0;
      recv_framing_error <= 1'b0;
      recv_break         <= 1'b0;
      recv_overrun       <= 1'b0;
    end else if (w_frame_end && (!recv_valid || recv_ready)) begin
      recv_data          <= w_is_break ? '0 : r_shift;
      recv_valid         <= 1'b1;
      recv_parity_error  <= r_perr & ~w_is_break;
      recv_framing_error <= w_is_break | r_ferr | ~w_vote;
      recv_break         <= w_is_break;
      recv_overrun       <= 1'b0;
    end else if (w_frame_end) begin
      recv_overrun <= 1'b1;
    end else if (recv_valid && recv_ready) begin
      recv_valid   <= 1'b0;
      recv_overrun <= 1'b0;
    end
  end

  assign recv_busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_receiver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_uart_frame_receiver
// Brief   : Scoreboard bench for an 8N1 and a 7E2 receiver instance.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_uart_frame_receiver;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
    logic       ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx1 = 1'b1;
  logic       rx2 = 1'b1;
  logic       ready1 = 1'b1;
  logic       ready2 = 1'b1;
  logic [7:0] data1;
  logic [6:0] data2;
  logic       valid1, perr1, ferr1, brk1, ovr1, busy1;
  logic       valid2, perr2, ferr2, brk2, ovr2, busy2;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  uart_frame_receiver #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut1 (
    .clk_baud_16x(clk), .reset_n(reset_n), .rx(rx1), .rx_enable(1'b1),
    .recv_data(data1), .recv_valid(valid1), .recv_ready(ready1),
    .recv_parity_error(perr1), .recv_framing_error(ferr1),
    .recv_break(brk1), .recv_overrun(ovr1), .recv_busy(busy1)
  );

  uart_frame_receiver #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut2 (
    .clk_baud_16x(clk), .reset_n(reset_n), .rx(rx2), .rx_enable(1'b1),
    .recv_data(data2), .recv_valid(valid2), .recv_ready(ready2),
    .recv_parity_error(perr2), .recv_framing_error(ferr2),
    .recv_break(brk2), .recv_overrun(ovr2), .recv_busy(busy2)
  );

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit sel, input logic v);
    if (sel) rx2 = v;
    else     rx1 = v;
    idle(16);
  endtask

  // par < 0 means no parity bit on the line.
  task automatic send_frame(input bit sel, input int nbits, input logic [8:0] data,
                            input int par, input int nstop, input logic stopval);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(sel, data[i]);
    if (par >= 0) drive_bit(sel, (par != 0));
    for (int i = 0; i < nstop; i++) drive_bit(sel, stopval);
    if (sel) rx2 = 1'b1;
    else     rx1 = 1'b1;
  endtask

  task automatic push1(input logic [8:0] d, input logic p, input logic f,
                       input logic b, input logic o);
    exp_t e;
    e.data = d; e.perr = p; e.ferr = f; e.brk = b; e.ovr = o;
    q1.push_back(e);
  endtask

  task automatic push2(input logic [8:0] d, input logic p);
    exp_t e;
    e.data = d; e.perr = p; e.ferr = 1'b0; e.brk = 1'b0; e.ovr = 1'b0;
    q2.push_back(e);
  endtask

  always @(negedge clk) begin
    if (valid1 && ready1) begin
      if (q1.size() == 0) begin
        check_value("dut1_unexpected_word", 32'(valid1), 32'd0);
      end else begin
        e1 = q1.pop_front();
        check_value("dut1_data", 32'(data1), 32'(e1.data));
        check_value("dut1_perr", 32'(perr1), 32'(e1.perr));
        check_value("dut1_ferr", 32'(ferr1), 32'(e1.ferr));
        check_value("dut1_break", 32'(brk1), 32'(e1.brk));
        check_value("dut1_overrun", 32'(ovr1), 32'(e1.ovr));
      end
    end
    if (valid2 && ready2) begin
      if (q2.size() == 0) begin
        check_value("dut2_unexpected_word", 32'(valid2), 32'd0);
      end else begin
        e2 = q2.pop_front();
        check_value("dut2_data", 32'(data2), 32'(e2.data));
        check_value("dut2_perr", 32'(perr2), 32'(e2.perr));
        check_value("dut2_ferr", 32'(ferr2), 32'(e2.ferr));
        check_value("dut2_break", 32'(brk2), 32'(e2.brk));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    idle(1);
    check_value("reset_outputs1", {data1, valid1, perr1, ferr1, brk1, ovr1, busy1}, 32'd0);
    check_value("reset_outputs2", {data2, valid2, perr2, ferr2, brk2, ovr2, busy2}, 32'd0);
    idle(3);
    reset_n = 1'b1;
    idle(20);

    // Plain 8N1 word and a word with a bad stop bit.
    push1(9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(1'b0, 8, 9'h0A5, -1, 1, 1'b1);
    check_value("t1_busy_after_stop", 32'(busy1), 32'd0);
    check_value("t1_valid_one_cycle", 32'(valid1), 32'd0);
    idle(20);
    check_value("t1_drained", q1.size(), 32'd0);
    push1(9'h03C, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(1'b0, 8, 9'h03C, -1, 1, 1'b0);
    idle(40);
    check_value("t1_ferr_drained", q1.size(), 32'd0);

    // 7E2: 0x35 has four ones, so even parity wants a 0 parity bit.
    push2(9'h035, 1'b0);
    send_frame(1'b1, 7, 9'h035, 0, 2, 1'b1);
    push2(9'h035, 1'b1);
    send_frame(1'b1, 7, 9'h035, 1, 2, 1'b1);
    push2(9'h034, 1'b0);
    send_frame(1'b1, 7, 9'h034, 1, 2, 1'b1);
    idle(20);
    check_value("t2_drained", q2.size(), 32'd0);

    // Short glitch: start is seen, then rejected by the mid-bit vote.
    rx1 = 1'b0;
    idle(3);
    rx1 = 1'b1;
    idle(3);
    check_value("t3_busy_in_start", 32'(busy1), 32'd1);
    idle(20);
    check_value("t3_busy_back_idle", 32'(busy1), 32'd0);
    check_value("t3_no_word", 32'(valid1), 32'd0);

    // Overrun: second word is dropped while the first is held.
    ready1 = 1'b0;
    push1(9'h011, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8, 9'h011, -1, 1, 1'b1);
    send_frame(1'b0, 8, 9'h022, -1, 1, 1'b1);
    idle(20);
    check_value("t4_valid_held", 32'(valid1), 32'd1);
    check_value("t4_data_held", 32'(data1), 32'h11);
    check_value("t4_overrun", 32'(ovr1), 32'd1);
    ready1 = 1'b1;
    idle(1);
    check_value("t4_valid_cleared", 32'(valid1), 32'd0);
    check_value("t4_overrun_cleared", 32'(ovr1), 32'd0);
    check_value("t4_drained", q1.size(), 32'd0);

    // Line break: 12 bit times low, then idle.
    push1(9'h000, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) drive_bit(1'b0, 1'b0);
    check_value("t5_busy_in_break", 32'(busy1), 32'd1);
    rx1 = 1'b1;
    idle(48);
    check_value("t5_busy_after_break", 32'(busy1), 32'd0);
    check_value("t5_drained", q1.size(), 32'd0);

    // Asynchronous reset mid-frame drops the held word and the partial frame.
    ready1 = 1'b0;
    send_frame(1'b0, 8, 9'h033, -1, 1, 1'b1);
    idle(10);
    check_value("t6_word_held", 32'(valid1), 32'd1);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    check_value("t6_async_reset1", {data1, valid1, perr1, ferr1, brk1, ovr1, busy1}, 32'd0);
    check_value("t6_async_reset2", {data2, valid2, perr2, ferr2, brk2, ovr2, busy2}, 32'd0);
    rx1 = 1'b1;
    idle(3);
    reset_n = 1'b1;
    ready1 = 1'b1;
    idle(10);
    push1(9'h05A, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(1'b0, 8, 9'h05A, -1, 1, 1'b1);
    idle(20);
    check_value("t6_drained", q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
